s_core_setup_loader: RTL
========================

Name: s_core_setup_loader

Overview:
- Initiator/writer for the pipelined core's setup interface: instruction-memory writes, register preload, start PC and the `setup` gate.
- Consumes a 32-bit command word stream over a valid/ready handshake, typically from a host bridge or boot ROM streamer.
- Decodes the stream into instruction-memory and register-file write strobes, drives the start PC, then releases the core from setup.
- Sits between the boot source and `s_core_pipelined`; replaces bench-driven setup.

Parameters:
- XLEN, 32, width of data words, addresses and PC.
- CNT_W, 16, width of the IMEM burst word-count field.
- RF_AW, 5, register-file address width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- i_word  in  XLEN  command/data stream word
- i_valid  in  1  i_word valid
- o_ready  out  1  loader accepts i_word this cycle
- o_setup  out  1  core held in setup mode
- o_inst_mem_we  out  1  one-cycle IMEM write strobe
- o_inst_mem_addr  out  XLEN  IMEM byte address
- o_inst_mem_data  out  XLEN  IMEM write data
- o_load_reg_we  out  1  one-cycle register write strobe
- o_load_reg_addr  out  RF_AW  register index
- o_load_reg_data  out  XLEN  register write data
- o_pc_start_addr  out  XLEN  start PC, held stable after release
- o_done  out  1  setup complete, core running
- o_err  out  1  sticky protocol error

Behaviour:
- A transfer occurs when i_valid && o_ready on a rising clk. o_ready is combinational from state: 1 in HDR, IMEM_ADDR, IMEM_DATA, REG_DATA and START_PC; 0 in RUN and ERR.
- Reset (rst_n=0 at a clk edge), from any state including mid-burst:
  - state=HDR, o_setup=1.
  - All strobes, addresses, data, o_pc_start_addr, o_done and o_err = 0.
  - Counter cleared.
- Header word: opcode in bits[31:24].
  - OP_IMEM=0x01: bits[CNT_W-1:0]=N words. Next word is the base byte address, followed by N data words.
  - OP_REG=0x02: bits[RF_AW-1:0]=register index. Next word is the data.
  - OP_START=0x03: next word is the start PC.
  - Any other opcode -> ERR.
- States and transitions:
  - HDR -> IMEM_ADDR / REG_DATA / START_PC / ERR, per opcode.
  - IMEM_ADDR:
    - Latch the address.
    - addr[1:0]!=0 -> ERR.
    - N==0 -> HDR, no write issued.
    - Otherwise -> IMEM_DATA.
  - IMEM_DATA:
    - Each accepted word produces o_inst_mem_we=1 exactly one cycle later, with o_inst_mem_addr/o_inst_mem_data registered.
    - The address advances by 4 per word, modulo 2^XLEN; 0xFFFFFFFC wraps to 0x00000000.
    - After the Nth word -> HDR. Back-to-back words give one write per cycle.
  - REG_DATA:
    - Accepting the data word produces o_load_reg_we=1 one cycle later.
    - Index 0 suppresses the strobe (x0 is read-only); this is not an error.
    - -> HDR.
  - START_PC:
    - Accepting the PC word registers o_pc_start_addr on that edge.
    - o_setup falls and o_done rises on the same edge (visible the next cycle).
    - PC with [1:0]!=0 -> ERR instead.
    - -> RUN.
  - RUN: terminal until reset. o_setup=0 and o_done=1 are held; the stream is ignored.
  - ERR: terminal until reset. o_err=1, o_setup stays 1, no further strobes.
- Strobes are never asserted while in RUN or ERR. At most one strobe type is active per cycle.
- i_valid low mid-burst: state and counter hold, no strobe, no timeout.
- Entering ERR mid-burst: strobes already pipelined for earlier accepted words still complete.

Decomposition:
- Package s_core_setup_pkg:
  - Opcode constants OP_IMEM, OP_REG, OP_START.
  - Loader state enum HDR, IMEM_ADDR, IMEM_DATA, REG_DATA, START_PC, RUN, ERR.
  - Opcode field bit positions.
- Single module. The burst counter and address incrementer stay inline; no natural sub-module.

Test Plan:
- Reset state: reset, then idle -> o_setup=1, o_ready=1, all strobes 0, o_done=0, o_err=0.
- IMEM burst: stream 0x01000003, 0x00000004, 0x00127413, 0x006201B3, 0x800AA937 -> three consecutive we pulses at addr 0x04, 0x08, 0x0C with that data. With i_valid gapped, each write is one cycle after its accept.
- Register loads: REG 0x02000004 data 0x00000001 -> one load_reg_we pulse, addr 4, data 1. Same sequence to index 0 -> no strobe, state returns to HDR.
- Start: START 0x03000000 PC 0x00000004 -> next cycle o_pc_start_addr=0x04, o_setup=0, o_done=1, o_ready=0. Further valid words produce no strobes.
- Errors (each from reset):
  - Header 0x7F000000 -> o_err=1 next cycle.
  - IMEM base 0x00000002 -> o_err=1.
  - Start PC 0x00000006 -> o_err=1, o_setup stays 1.
- Wrap and reset mid-burst:
  - IMEM N=2 at 0xFFFFFFFC -> writes to 0xFFFFFFFC then 0x00000000.
  - rst_n low after 1 of 3 words -> all outputs return to reset values; a fresh header is then accepted normally.

Source files
------------

// File: rtl/s_core_setup_pkg.sv
// ---------------------------------------------------------------------------
// s_core_setup_pkg
// Shared definitions for the pipelined core setup loader: command opcodes,
// the opcode field position inside a header word, and the loader FSM states.
// ---------------------------------------------------------------------------
package s_core_setup_pkg;

   // Opcode field occupies the top byte of a header word
   localparam int OP_MSB = 31;
   localparam int OP_LSB = 24;
   localparam int OP_W   = OP_MSB - OP_LSB + 1;

   localparam logic [OP_W-1:0] OP_IMEM  = 8'h01;
   localparam logic [OP_W-1:0] OP_REG   = 8'h02;
   localparam logic [OP_W-1:0] OP_START = 8'h03;

   typedef enum logic [2:0] {
      HDR       = 3'd0,
      IMEM_ADDR = 3'd1,
      IMEM_DATA = 3'd2,
      REG_DATA  = 3'd3,
      START_PC  = 3'd4,
      RUN       = 3'd5,
      ERR       = 3'd6
   } loader_state_t;

endpackage

// File: rtl/s_core_setup_loader.sv
// ---------------------------------------------------------------------------
// s_core_setup_loader
// Turns a 32-bit command stream (valid/ready) into the setup traffic of the
// pipelined core: instruction-memory burst writes, register preloads, the
// start PC, and finally release of the core from setup mode.
//
// Ports:
//   clk, rst_n            core clock, synchronous active-low reset
//   i_word, i_valid       command/data stream word and its valid
//   o_ready               loader accepts i_word this cycle
//   o_setup               core held in setup mode
//   o_inst_mem_we/addr/data   one-cycle IMEM write strobe, byte address, data
//   o_load_reg_we/addr/data   one-cycle register write strobe, index, data
//   o_pc_start_addr       start PC, stable once the core runs
//   o_done                setup complete, core running
//   o_err                 sticky protocol error (cleared only by reset)
// ---------------------------------------------------------------------------
module s_core_setup_loader
   import s_core_setup_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16,
   parameter int RF_AW = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [XLEN-1:0]  i_word,
   input  logic             i_valid,
   output logic             o_ready,
   output logic             o_setup,
   output logic             o_inst_mem_we,
   output logic [XLEN-1:0]  o_inst_mem_addr,
   output logic [XLEN-1:0]  o_inst_mem_data,
   output logic             o_load_reg_we,
   output logic [RF_AW-1:0] o_load_reg_addr,
   output logic [XLEN-1:0]  o_load_reg_data,
   output logic [XLEN-1:0]  o_pc_start_addr,
   output logic             o_done,
   output logic             o_err
);

   loader_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [XLEN-1:0]  addr_q;
   logic [RF_AW-1:0] reg_idx_q;
   logic [OP_W-1:0]  opcode;
   logic             xfer;

   // Datapath control decoded alongside the next state
   logic load_cnt, load_idx, load_addr, imem_wr, reg_wr, start_ok;

   // Status outputs are pure decodes of the registered state, so they change
   // on the same edge that moves the FSM.
   always_comb begin
      o_ready = (state_q != RUN) && (state_q != ERR);
      xfer    = i_valid && o_ready;
      opcode  = i_word[OP_MSB:OP_LSB];
      o_setup = (state_q != RUN);
      o_done  = (state_q == RUN);
      o_err   = (state_q == ERR);
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= HDR;
      else        state_q <= state_d;
   end

   // Next-state and datapath-control decode; nothing moves without a transfer
   always_comb begin
      state_d   = state_q;
      load_cnt  = 1'b0;
      load_idx  = 1'b0;
      load_addr = 1'b0;
      imem_wr   = 1'b0;
      reg_wr    = 1'b0;
      start_ok  = 1'b0;
      if (xfer) begin
         case (state_q)
            HDR: begin
               case (opcode)
                  OP_IMEM:  begin state_d = IMEM_ADDR; load_cnt = 1'b1; end
                  OP_REG:   begin state_d = REG_DATA;  load_idx = 1'b1; end
                  OP_START: state_d = START_PC;
                  default:  state_d = ERR;
               endcase
            end
            IMEM_ADDR: begin
               load_addr = 1'b1;
               if (i_word[1:0] != 2'b00) state_d = ERR;
               else if (cnt_q == '0)     state_d = HDR;
               else                      state_d = IMEM_DATA;
            end
            IMEM_DATA: begin
               imem_wr = 1'b1;
               if (cnt_q == CNT_W'(1)) state_d = HDR;
            end
            REG_DATA: begin
               // Writes to x0 are silently dropped; the command is still legal
               reg_wr  = (reg_idx_q != '0);
               state_d = HDR;
            end
            START_PC: begin
               if (i_word[1:0] != 2'b00) state_d = ERR;
               else begin
                  start_ok = 1'b1;
                  state_d  = RUN;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Burst counter, running IMEM address and the registered write ports.
   // Strobes default low every cycle so each accepted word gives one pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q           <= '0;
         addr_q          <= '0;
         reg_idx_q       <= '0;
         o_inst_mem_we   <= 1'b0;
         o_inst_mem_addr <= '0;
         o_inst_mem_data <= '0;
         o_load_reg_we   <= 1'b0;
         o_load_reg_addr <= '0;
         o_load_reg_data <= '0;
         o_pc_start_addr <= '0;
      end else begin
         o_inst_mem_we <= imem_wr;
         o_load_reg_we <= reg_wr;
         if (load_cnt)  cnt_q     <= i_word[CNT_W-1:0];
         if (load_idx)  reg_idx_q <= i_word[RF_AW-1:0];
         if (load_addr) addr_q    <= i_word;
         if (imem_wr) begin
            o_inst_mem_addr <= addr_q;
            o_inst_mem_data <= i_word;
            // Natural modulo-2^XLEN wrap of the byte address
            addr_q          <= addr_q + XLEN'(4);
            cnt_q           <= cnt_q - CNT_W'(1);
         end
         if (reg_wr) begin
            o_load_reg_addr <= reg_idx_q;
            o_load_reg_data <= i_word;
         end
         if (start_ok) o_pc_start_addr <= i_word;
      end
   end

endmodule
